// File: rtl/tl_l2_bank_xbar.sv
// Address-interleaved TileLink-C crossbar: one client manager port to NBANKS L2 banks.
// A/C route by line-address bank bits, E by the bank tag in the sink; D/B merge via round-robin.
module tl_l2_bank_xbar #(
  parameter int NBANKS   = 2,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 6,
  parameter int SINK_W   = 4,
  parameter int CID_W    = 2,
  parameter int BANK_LSB = 6,
  localparam int BW      = (NBANKS > 1) ? $clog2(NBANKS) : 0,
  localparam int LSW     = SINK_W - BW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // upstream A
  input  logic                       up_a_valid_i,
  output logic                       up_a_ready_o,
  input  logic [2:0]                 up_a_opcode_i,
  input  logic [2:0]                 up_a_param_i,
  input  logic [3:0]                 up_a_size_i,
  input  logic [SOURCE_W-1:0]        up_a_source_i,
  input  logic [ADDR_W-1:0]          up_a_address_i,
  input  logic [7:0]                 up_a_mask_i,
  input  logic [DATA_W-1:0]          up_a_data_i,
  input  logic                       up_a_corrupt_i,
  // upstream B
  output logic                       up_b_valid_o,
  input  logic                       up_b_ready_i,
  output logic [2:0]                 up_b_opcode_o,
  output logic [2:0]                 up_b_param_o,
  output logic [3:0]                 up_b_size_o,
  output logic [ADDR_W-1:0]          up_b_address_o,
  output logic [CID_W-1:0]           up_b_dest_o,
  // upstream C
  input  logic                       up_c_valid_i,
  output logic                       up_c_ready_o,
  input  logic [2:0]                 up_c_opcode_i,
  input  logic [2:0]                 up_c_param_i,
  input  logic [3:0]                 up_c_size_i,
  input  logic [SOURCE_W-1:0]        up_c_source_i,
  input  logic [ADDR_W-1:0]          up_c_address_i,
  input  logic [DATA_W-1:0]          up_c_data_i,
  input  logic                       up_c_corrupt_i,
  // upstream D
  output logic                       up_d_valid_o,
  input  logic                       up_d_ready_i,
  output logic [2:0]                 up_d_opcode_o,
  output logic [1:0]                 up_d_param_o,
  output logic [3:0]                 up_d_size_o,
  output logic [SOURCE_W-1:0]        up_d_source_o,
  output logic [SINK_W-1:0]          up_d_sink_o,
  output logic                       up_d_denied_o,
  output logic [DATA_W-1:0]          up_d_data_o,
  output logic                       up_d_corrupt_o,
  // upstream E
  input  logic                       up_e_valid_i,
  output logic                       up_e_ready_o,
  input  logic [SINK_W-1:0]          up_e_sink_i,
  // bank A
  output logic [NBANKS-1:0]          bk_a_valid_o,
  input  logic [NBANKS-1:0]          bk_a_ready_i,
  output logic [NBANKS*3-1:0]        bk_a_opcode_o,
  output logic [NBANKS*3-1:0]        bk_a_param_o,
  output logic [NBANKS*4-1:0]        bk_a_size_o,
  output logic [NBANKS*SOURCE_W-1:0] bk_a_source_o,
  output logic [NBANKS*ADDR_W-1:0]   bk_a_address_o,
  output logic [NBANKS*8-1:0]        bk_a_mask_o,
  output logic [NBANKS*DATA_W-1:0]   bk_a_data_o,
  output logic [NBANKS-1:0]          bk_a_corrupt_o,
  // bank B
  input  logic [NBANKS-1:0]          bk_b_valid_i,
  output logic [NBANKS-1:0]          bk_b_ready_o,
  input  logic [NBANKS*3-1:0]        bk_b_opcode_i,
  input  logic [NBANKS*3-1:0]        bk_b_param_i,
  input  logic [NBANKS*4-1:0]        bk_b_size_i,
  input  logic [NBANKS*ADDR_W-1:0]   bk_b_address_i,
  input  logic [NBANKS*CID_W-1:0]    bk_b_dest_i,
  // bank C
  output logic [NBANKS-1:0]          bk_c_valid_o,
  input  logic [NBANKS-1:0]          bk_c_ready_i,
  output logic [NBANKS*3-1:0]        bk_c_opcode_o,
  output logic [NBANKS*3-1:0]        bk_c_param_o,
  output logic [NBANKS*4-1:0]        bk_c_size_o,
  output logic [NBANKS*SOURCE_W-1:0] bk_c_source_o,
  output logic [NBANKS*ADDR_W-1:0]   bk_c_address_o,
  output logic [NBANKS*DATA_W-1:0]   bk_c_data_o,
  output logic [NBANKS-1:0]          bk_c_corrupt_o,
  // bank D
  input  logic [NBANKS-1:0]          bk_d_valid_i,
  output logic [NBANKS-1:0]          bk_d_ready_o,
  input  logic [NBANKS*3-1:0]        bk_d_opcode_i,
  input  logic [NBANKS*2-1:0]        bk_d_param_i,
  input  logic [NBANKS*4-1:0]        bk_d_size_i,
  input  logic [NBANKS*SOURCE_W-1:0] bk_d_source_i,
  input  logic [NBANKS*LSW-1:0]      bk_d_sink_i,
  input  logic [NBANKS-1:0]          bk_d_denied_i,
  input  logic [NBANKS*DATA_W-1:0]   bk_d_data_i,
  input  logic [NBANKS-1:0]          bk_d_corrupt_i,
  // bank E
  output logic [NBANKS-1:0]          bk_e_valid_o,
  input  logic [NBANKS-1:0]          bk_e_ready_i,
  output logic [NBANKS*LSW-1:0]      bk_e_sink_o
);

  localparam int BIW     = (BW > 0) ? BW : 1;
  localparam int BEAT_LG = $clog2(DATA_W / 8);

  logic [BIW-1:0] a_bank, c_bank, e_bank;
  logic [BIW-1:0] rr_d_q, rr_b_q, d_lock_bank_q;
  logic [BIW-1:0] d_grant, b_grant, d_idx, b_idx, d_next, b_next;
  logic           d_locked_q, d_any, b_any, d_fire, b_fire, d_too_big;
  logic [7:0]     d_cnt_q, d_beats_m1;
  int             d_sel, b_sel, d_shift;

  // Payload is broadcast; only the selected bank's valid is raised.
  assign bk_a_opcode_o  = {NBANKS{up_a_opcode_i}};
  assign bk_a_param_o   = {NBANKS{up_a_param_i}};
  assign bk_a_size_o    = {NBANKS{up_a_size_i}};
  assign bk_a_source_o  = {NBANKS{up_a_source_i}};
  assign bk_a_address_o = {NBANKS{up_a_address_i}};
  assign bk_a_mask_o    = {NBANKS{up_a_mask_i}};
  assign bk_a_data_o    = {NBANKS{up_a_data_i}};
  assign bk_a_corrupt_o = {NBANKS{up_a_corrupt_i}};
  assign bk_c_opcode_o  = {NBANKS{up_c_opcode_i}};
  assign bk_c_param_o   = {NBANKS{up_c_param_i}};
  assign bk_c_size_o    = {NBANKS{up_c_size_i}};
  assign bk_c_source_o  = {NBANKS{up_c_source_i}};
  assign bk_c_address_o = {NBANKS{up_c_address_i}};
  assign bk_c_data_o    = {NBANKS{up_c_data_i}};
  assign bk_c_corrupt_o = {NBANKS{up_c_corrupt_i}};
  assign bk_e_sink_o    = {NBANKS{up_e_sink_i[LSW-1:0]}};

  generate
    if (BW == 0) begin : g_one_bank
      assign a_bank      = '0;
      assign c_bank      = '0;
      assign e_bank      = '0;
      assign up_d_sink_o = bk_d_sink_i[d_sel*LSW +: LSW];
    end else begin : g_multi_bank
      assign a_bank      = up_a_address_i[BANK_LSB +: BW];
      assign c_bank      = up_c_address_i[BANK_LSB +: BW];
      assign e_bank      = up_e_sink_i[SINK_W-1 -: BW];
      assign up_d_sink_o = {d_grant, bk_d_sink_i[d_sel*LSW +: LSW]};
    end
  endgenerate

  always_comb begin
    bk_a_valid_o = '0;
    bk_c_valid_o = '0;
    bk_e_valid_o = '0;
    up_a_ready_o = 1'b0;
    up_c_ready_o = 1'b0;
    up_e_ready_o = 1'b0;
    if (rst_ni) begin
      bk_a_valid_o[a_bank] = up_a_valid_i;
      bk_c_valid_o[c_bank] = up_c_valid_i;
      bk_e_valid_o[e_bank] = up_e_valid_i;
      up_a_ready_o         = bk_a_ready_i[a_bank];
      up_c_ready_o         = bk_c_ready_i[c_bank];
      up_e_ready_o         = bk_e_ready_i[e_bank];
    end
  end

  // Round-robin search: walking down from the farthest candidate lets the nearest one win.
  always_comb begin
    d_grant = rr_d_q;
    d_any   = 1'b0;
    d_idx   = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      d_idx = rr_d_q + BIW'(i);
      if (bk_d_valid_i[d_idx]) begin
        d_grant = d_idx;
        d_any   = 1'b1;
      end
    end
    if (d_locked_q) begin
      d_grant = d_lock_bank_q;
      d_any   = bk_d_valid_i[d_lock_bank_q];
    end
  end

  always_comb begin
    b_grant = rr_b_q;
    b_any   = 1'b0;
    b_idx   = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      b_idx = rr_b_q + BIW'(i);
      if (bk_b_valid_i[b_idx]) begin
        b_grant = b_idx;
        b_any   = 1'b1;
      end
    end
  end

  assign d_sel  = int'(d_grant);
  assign b_sel  = int'(b_grant);
  assign d_next = (NBANKS == 1) ? '0 : d_grant + BIW'(1);
  assign b_next = (NBANKS == 1) ? '0 : b_grant + BIW'(1);

  assign up_d_valid_o   = rst_ni & d_any;
  assign d_fire         = up_d_valid_o & up_d_ready_i;
  assign up_d_opcode_o  = bk_d_opcode_i[d_sel*3 +: 3];
  assign up_d_param_o   = bk_d_param_i[d_sel*2 +: 2];
  assign up_d_size_o    = bk_d_size_i[d_sel*4 +: 4];
  assign up_d_source_o  = bk_d_source_i[d_sel*SOURCE_W +: SOURCE_W];
  assign up_d_denied_o  = bk_d_denied_i[d_sel];
  assign up_d_data_o    = bk_d_data_i[d_sel*DATA_W +: DATA_W];
  assign up_d_corrupt_o = bk_d_corrupt_i[d_sel];

  assign up_b_valid_o   = rst_ni & b_any;
  assign b_fire         = up_b_valid_o & up_b_ready_i;
  assign up_b_opcode_o  = bk_b_opcode_i[b_sel*3 +: 3];
  assign up_b_param_o   = bk_b_param_i[b_sel*3 +: 3];
  assign up_b_size_o    = bk_b_size_i[b_sel*4 +: 4];
  assign up_b_address_o = bk_b_address_i[b_sel*ADDR_W +: ADDR_W];
  assign up_b_dest_o    = bk_b_dest_i[b_sel*CID_W +: CID_W];

  always_comb begin
    bk_d_ready_o = '0;
    bk_b_ready_o = '0;
    if (rst_ni && d_any) bk_d_ready_o[d_grant] = up_d_ready_i;
    if (rst_ni && b_any) bk_b_ready_o[b_grant] = up_b_ready_i;
  end

  // Only AccessAckData and GrantData carry multiple beats; the count saturates at 256 beats.
  always_comb begin
    d_beats_m1 = '0;
    d_too_big  = 1'b0;
    d_shift    = 0;
    if ((up_d_opcode_o == 3'd1 || up_d_opcode_o == 3'd5) && int'(up_d_size_o) > BEAT_LG) begin
      d_shift = int'(up_d_size_o) - BEAT_LG;
      if (d_shift > 8) begin
        d_too_big  = 1'b1;
        d_beats_m1 = 8'hFF;
      end else begin
        d_beats_m1 = 8'((32'd1 << d_shift) - 32'd1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_d_q        <= '0;
      rr_b_q        <= '0;
      d_locked_q    <= 1'b0;
      d_lock_bank_q <= '0;
      d_cnt_q       <= '0;
    end else begin
      if (d_fire) begin
        if (d_locked_q) begin
          if (d_cnt_q <= 8'd1) begin
            d_locked_q <= 1'b0;
            d_cnt_q    <= '0;
            rr_d_q     <= d_next;
          end else begin
            d_cnt_q <= d_cnt_q - 8'd1;
          end
        end else if (d_beats_m1 != 8'd0) begin
          d_locked_q    <= 1'b1;
          d_lock_bank_q <= d_grant;
          d_cnt_q       <= d_beats_m1;
        end else begin
          rr_d_q <= d_next;
        end
      end
      if (b_fire) rr_b_q <= b_next;
    end
  end

  a_d_burst_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(d_fire && !d_locked_q && d_too_big));

endmodule

// File: tb/tb_tl_l2_bank_xbar.sv
// Bench for tl_l2_bank_xbar with NBANKS=2: bank D models fed from queues, scoreboard of expected D beats.
module tb_tl_l2_bank_xbar;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic up_a_valid_i, up_a_ready_o, up_a_corrupt_i;
  logic [2:0] up_a_opcode_i, up_a_param_i;
  logic [3:0] up_a_size_i;
  logic [5:0] up_a_source_i;
  logic [63:0] up_a_address_i, up_a_data_i;
  logic [7:0] up_a_mask_i;
  logic up_b_valid_o, up_b_ready_i;
  logic [2:0] up_b_opcode_o, up_b_param_o;
  logic [3:0] up_b_size_o;
  logic [63:0] up_b_address_o;
  logic [1:0] up_b_dest_o;
  logic up_c_valid_i, up_c_ready_o, up_c_corrupt_i;
  logic [2:0] up_c_opcode_i, up_c_param_i;
  logic [3:0] up_c_size_i;
  logic [5:0] up_c_source_i;
  logic [63:0] up_c_address_i, up_c_data_i;
  logic up_d_valid_o, up_d_ready_i, up_d_denied_o, up_d_corrupt_o;
  logic [2:0] up_d_opcode_o;
  logic [1:0] up_d_param_o;
  logic [3:0] up_d_size_o, up_d_sink_o;
  logic [5:0] up_d_source_o;
  logic [63:0] up_d_data_o;
  logic up_e_valid_i, up_e_ready_o;
  logic [3:0] up_e_sink_i;
  logic [1:0] bk_a_valid_o, bk_a_ready_i, bk_a_corrupt_o;
  logic [5:0] bk_a_opcode_o, bk_a_param_o;
  logic [7:0] bk_a_size_o;
  logic [11:0] bk_a_source_o;
  logic [127:0] bk_a_address_o, bk_a_data_o;
  logic [15:0] bk_a_mask_o;
  logic [1:0] bk_b_valid_i, bk_b_ready_o;
  logic [5:0] bk_b_opcode_i, bk_b_param_i;
  logic [7:0] bk_b_size_i;
  logic [127:0] bk_b_address_i;
  logic [3:0] bk_b_dest_i;
  logic [1:0] bk_c_valid_o, bk_c_ready_i, bk_c_corrupt_o;
  logic [5:0] bk_c_opcode_o, bk_c_param_o;
  logic [7:0] bk_c_size_o;
  logic [11:0] bk_c_source_o;
  logic [127:0] bk_c_address_o, bk_c_data_o;
  logic [1:0] bk_d_valid_i, bk_d_ready_o, bk_d_denied_i, bk_d_corrupt_i;
  logic [5:0] bk_d_opcode_i, bk_d_sink_i;
  logic [3:0] bk_d_param_i;
  logic [7:0] bk_d_size_i;
  logic [11:0] bk_d_source_i;
  logic [127:0] bk_d_data_i;
  logic [1:0] bk_e_valid_o, bk_e_ready_i;
  logic [5:0] bk_e_sink_o;

  tl_l2_bank_xbar dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .up_a_valid_i(up_a_valid_i), .up_a_ready_o(up_a_ready_o), .up_a_opcode_i(up_a_opcode_i),
    .up_a_param_i(up_a_param_i), .up_a_size_i(up_a_size_i), .up_a_source_i(up_a_source_i),
    .up_a_address_i(up_a_address_i), .up_a_mask_i(up_a_mask_i), .up_a_data_i(up_a_data_i),
    .up_a_corrupt_i(up_a_corrupt_i),
    .up_b_valid_o(up_b_valid_o), .up_b_ready_i(up_b_ready_i), .up_b_opcode_o(up_b_opcode_o),
    .up_b_param_o(up_b_param_o), .up_b_size_o(up_b_size_o), .up_b_address_o(up_b_address_o),
    .up_b_dest_o(up_b_dest_o),
    .up_c_valid_i(up_c_valid_i), .up_c_ready_o(up_c_ready_o), .up_c_opcode_i(up_c_opcode_i),
    .up_c_param_i(up_c_param_i), .up_c_size_i(up_c_size_i), .up_c_source_i(up_c_source_i),
    .up_c_address_i(up_c_address_i), .up_c_data_i(up_c_data_i), .up_c_corrupt_i(up_c_corrupt_i),
    .up_d_valid_o(up_d_valid_o), .up_d_ready_i(up_d_ready_i), .up_d_opcode_o(up_d_opcode_o),
    .up_d_param_o(up_d_param_o), .up_d_size_o(up_d_size_o), .up_d_source_o(up_d_source_o),
    .up_d_sink_o(up_d_sink_o), .up_d_denied_o(up_d_denied_o), .up_d_data_o(up_d_data_o),
    .up_d_corrupt_o(up_d_corrupt_o),
    .up_e_valid_i(up_e_valid_i), .up_e_ready_o(up_e_ready_o), .up_e_sink_i(up_e_sink_i),
    .bk_a_valid_o(bk_a_valid_o), .bk_a_ready_i(bk_a_ready_i), .bk_a_opcode_o(bk_a_opcode_o),
    .bk_a_param_o(bk_a_param_o), .bk_a_size_o(bk_a_size_o), .bk_a_source_o(bk_a_source_o),
    .bk_a_address_o(bk_a_address_o), .bk_a_mask_o(bk_a_mask_o), .bk_a_data_o(bk_a_data_o),
    .bk_a_corrupt_o(bk_a_corrupt_o),
    .bk_b_valid_i(bk_b_valid_i), .bk_b_ready_o(bk_b_ready_o), .bk_b_opcode_i(bk_b_opcode_i),
    .bk_b_param_i(bk_b_param_i), .bk_b_size_i(bk_b_size_i), .bk_b_address_i(bk_b_address_i),
    .bk_b_dest_i(bk_b_dest_i),
    .bk_c_valid_o(bk_c_valid_o), .bk_c_ready_i(bk_c_ready_i), .bk_c_opcode_o(bk_c_opcode_o),
    .bk_c_param_o(bk_c_param_o), .bk_c_size_o(bk_c_size_o), .bk_c_source_o(bk_c_source_o),
    .bk_c_address_o(bk_c_address_o), .bk_c_data_o(bk_c_data_o), .bk_c_corrupt_o(bk_c_corrupt_o),
    .bk_d_valid_i(bk_d_valid_i), .bk_d_ready_o(bk_d_ready_o), .bk_d_opcode_i(bk_d_opcode_i),
    .bk_d_param_i(bk_d_param_i), .bk_d_size_i(bk_d_size_i), .bk_d_source_i(bk_d_source_i),
    .bk_d_sink_i(bk_d_sink_i), .bk_d_denied_i(bk_d_denied_i), .bk_d_data_i(bk_d_data_i),
    .bk_d_corrupt_i(bk_d_corrupt_i),
    .bk_e_valid_o(bk_e_valid_o), .bk_e_ready_i(bk_e_ready_i), .bk_e_sink_o(bk_e_sink_o)
  );

  typedef struct packed {logic [2:0] op; logic [3:0] size; logic [2:0] sink; logic [63:0] data;} dbeat_t;
  typedef struct packed {logic [3:0] sink; logic [2:0] op; logic [63:0] data;} dexp_t;

  dbeat_t bq0[$], bq1[$];
  dexp_t  exp_q[$];
  bit     hold0 = 1'b0;
  bit     f0 = 1'b0, f1 = 1'b0;
  int     checks = 0, errors = 0;

  task automatic drive_banks();
    bk_d_valid_i[0] = (bq0.size() > 0) && !hold0;
    bk_d_valid_i[1] = (bq1.size() > 0);
    if (bq0.size() > 0) begin
      bk_d_opcode_i[2:0] = bq0[0].op;  bk_d_size_i[3:0] = bq0[0].size;
      bk_d_sink_i[2:0]   = bq0[0].sink; bk_d_data_i[63:0] = bq0[0].data;
    end
    if (bq1.size() > 0) begin
      bk_d_opcode_i[5:3] = bq1[0].op;  bk_d_size_i[7:4] = bq1[0].size;
      bk_d_sink_i[5:3]   = bq1[0].sink; bk_d_data_i[127:64] = bq1[0].data;
    end
  endtask

  task automatic load(input int bank, input logic [2:0] op, input logic [3:0] size,
                      input logic [2:0] sink, input logic [63:0] data);
    if (bank == 0) bq0.push_back('{op, size, sink, data});
    else bq1.push_back('{op, size, sink, data});
  endtask

  task automatic expect_d(input logic [3:0] sink, input logic [2:0] op, input logic [63:0] data);
    exp_q.push_back('{sink, op, data});
  endtask

  task automatic wait_drain(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk_i); #2;
      n++;
    end while ((exp_q.size() != 0 || bq0.size() != 0 || bq1.size() != 0) && n < max);
  endtask

  // Scoreboard: every upstream D handshake is matched against the head of exp_q.
  always @(negedge clk_i) begin
    dexp_t e;
    f0 = bk_d_valid_i[0] & bk_d_ready_o[0];
    f1 = bk_d_valid_i[1] & bk_d_ready_o[1];
    if (up_d_valid_o && up_d_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected: got sink=%h op=%0d data=%h, expected no beat",
                 up_d_sink_o, up_d_opcode_o, up_d_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({up_d_sink_o, up_d_opcode_o, up_d_data_o} !== e) begin
          errors++;
          $display("FAIL d_beat: got sink=%h op=%0d data=%h, expected sink=%h op=%0d data=%h",
                   up_d_sink_o, up_d_opcode_o, up_d_data_o, e.sink, e.op, e.data);
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (f0 && bq0.size() > 0) void'(bq0.pop_front());
    if (f1 && bq1.size() > 0) void'(bq1.pop_front());
    f0 = 1'b0;
    f1 = 1'b0;
    drive_banks();
  end

  task automatic test_reset();
    up_a_valid_i = 1'b1; up_a_address_i = 64'h40; bk_a_ready_i = 2'b11;
    up_c_valid_i = 1'b1; up_c_address_i = 64'h0;  bk_c_ready_i = 2'b11;
    up_e_valid_i = 1'b1; up_e_sink_i = 4'h0;      bk_e_ready_i = 2'b11;
    bk_d_valid_i = 2'b11; bk_b_valid_i = 2'b11; up_d_ready_i = 1'b1; up_b_ready_i = 1'b1;
    #3;
    checks++;
    if ({up_a_ready_o, up_c_ready_o, up_e_ready_o, up_d_valid_o, up_b_valid_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_up: got a_rdy/c_rdy/e_rdy/d_vld/b_vld=%b, expected 00000",
               {up_a_ready_o, up_c_ready_o, up_e_ready_o, up_d_valid_o, up_b_valid_o});
    end
    checks++;
    if ({bk_a_valid_o, bk_c_valid_o, bk_e_valid_o, bk_d_ready_o, bk_b_ready_o} !== 10'b0) begin
      errors++;
      $display("FAIL reset_bk: got %b, expected all zero",
               {bk_a_valid_o, bk_c_valid_o, bk_e_valid_o, bk_d_ready_o, bk_b_ready_o});
    end
    up_a_valid_i = 1'b0; up_c_valid_i = 1'b0; up_e_valid_i = 1'b0;
    bk_b_valid_i = 2'b00;
    drive_banks();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_a_c_route();
    @(posedge clk_i); #2;
    up_a_valid_i = 1'b1; up_a_opcode_i = 3'd4; up_a_source_i = 6'h2A;
    up_a_address_i = 64'h40; bk_a_ready_i = 2'b01;
    #1;
    checks++;
    if (bk_a_valid_o !== 2'b10 || up_a_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL a_route_0x40: got valid=%b ready=%b, expected valid=10 ready=0", bk_a_valid_o, up_a_ready_o);
    end
    checks++;
    if (bk_a_source_o !== {6'h2A, 6'h2A} || bk_a_opcode_o !== {3'd4, 3'd4}) begin
      errors++;
      $display("FAIL a_broadcast: got source=%h opcode=%h, expected aaa and 24", bk_a_source_o, bk_a_opcode_o);
    end
    bk_a_ready_i = 2'b10; #1;
    checks++;
    if (up_a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL a_ready_bank1: got %b, expected 1", up_a_ready_o);
    end
    up_a_address_i = 64'h80; #1;
    checks++;
    if (bk_a_valid_o !== 2'b01 || up_a_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL a_route_0x80: got valid=%b ready=%b, expected valid=01 ready=0", bk_a_valid_o, up_a_ready_o);
    end
    up_a_valid_i = 1'b0;
    up_c_valid_i = 1'b1; up_c_address_i = 64'hC0; bk_c_ready_i = 2'b10; #1;
    checks++;
    if (bk_c_valid_o !== 2'b10 || up_c_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL c_route_0xc0: got valid=%b ready=%b, expected valid=10 ready=1", bk_c_valid_o, up_c_ready_o);
    end
    up_c_valid_i = 1'b0;
  endtask

  task automatic test_d_round_robin();
    int n;
    @(posedge clk_i); #2;
    load(0, 3'd0, 4'd3, 3'h1, 64'hA0); load(0, 3'd0, 4'd3, 3'h1, 64'hA2);
    load(1, 3'd0, 4'd3, 3'h2, 64'hA1); load(1, 3'd0, 4'd3, 3'h2, 64'hA3);
    expect_d(4'h1, 3'd0, 64'hA0); expect_d(4'hA, 3'd0, 64'hA1);
    expect_d(4'h1, 3'd0, 64'hA2); expect_d(4'hA, 3'd0, 64'hA3);
    drive_banks();
    wait_drain(40, n);
    checks++;
    if (n !== 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL d_rr_cycles: got %0d cycles (%0d left), expected 4 cycles", n, exp_q.size());
    end
  endtask

  task automatic test_d_burst_lock();
    int n;
    @(posedge clk_i); #2;
    for (int i = 0; i < 8; i++) begin
      load(0, 3'd5, 4'd6, 3'h2, 64'h100 + 64'(i));
      expect_d(4'h2, 3'd5, 64'h100 + 64'(i));
    end
    load(1, 3'd0, 4'd3, 3'h3, 64'hB1);
    expect_d(4'hB, 3'd0, 64'hB1);
    drive_banks();
    wait_drain(60, n);
    checks++;
    if (n !== 9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL d_burst_cycles: got %0d cycles (%0d left), expected 9 cycles", n, exp_q.size());
    end
  endtask

  task automatic test_d_burst_stall();
    int n;
    @(posedge clk_i); #2;
    for (int i = 0; i < 8; i++) begin
      load(0, 3'd5, 4'd6, 3'h4, 64'h200 + 64'(i));
      expect_d(4'h4, 3'd5, 64'h200 + 64'(i));
    end
    load(1, 3'd0, 4'd3, 3'h6, 64'hC1);
    expect_d(4'hE, 3'd0, 64'hC1);
    drive_banks();
    n = 0;
    while (bq0.size() > 5 && n < 20) begin
      @(posedge clk_i); #2;
      n++;
    end
    hold0 = 1'b1;
    drive_banks();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if (up_d_valid_o !== 1'b0 || bk_d_ready_o !== 2'b00 || bq0.size() != 5) begin
        errors++;
        $display("FAIL d_stall_hold: got d_valid=%b bk_ready=%b pending=%0d, expected 0, 00, 5",
                 up_d_valid_o, bk_d_ready_o, bq0.size());
      end
      @(posedge clk_i); #2;
    end
    hold0 = 1'b0;
    drive_banks();
    wait_drain(60, n);
    checks++;
    if (exp_q.size() != 0 || n >= 60) begin
      errors++;
      $display("FAIL d_stall_resume: got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_sink_e();
    int n;
    @(posedge clk_i); #2;
    load(1, 3'd4, 4'd6, 3'h5, 64'hD5);
    expect_d(4'hD, 3'd4, 64'hD5);
    drive_banks();
    wait_drain(20, n);
    checks++;
    if (n !== 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL grant_sink_cycles: got %0d cycles, expected 1", n);
    end
    up_e_valid_i = 1'b1; up_e_sink_i = 4'hD; bk_e_ready_i = 2'b10; #1;
    checks++;
    if (bk_e_valid_o !== 2'b10 || bk_e_sink_o[5:3] !== 3'h5 || up_e_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL e_route_d: got valid=%b sink=%h ready=%b, expected 10, 5, 1",
               bk_e_valid_o, bk_e_sink_o[5:3], up_e_ready_o);
    end
    bk_e_ready_i = 2'b01; up_e_sink_i = 4'h3; #1;
    checks++;
    if (bk_e_valid_o !== 2'b01 || bk_e_sink_o[2:0] !== 3'h3 || up_e_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL e_route_3: got valid=%b sink=%h ready=%b, expected 01, 3, 1",
               bk_e_valid_o, bk_e_sink_o[2:0], up_e_ready_o);
    end
    up_e_valid_i = 1'b0;
  endtask

  task automatic test_b_round_robin();
    logic [1:0] exp_dest;
    logic [1:0] exp_rdy;
    @(posedge clk_i); #2;
    bk_b_valid_i = 2'b11; bk_b_dest_i = {2'd2, 2'd1};
    bk_b_address_i = {64'h1040, 64'h1000};
    bk_b_opcode_i = {3'd6, 3'd6}; bk_b_param_i = '0; bk_b_size_i = {4'd6, 4'd6};
    up_b_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // Cycle 2 stalls upstream; the grant must hold on bank 0.
      up_b_ready_i = (i != 2);
      exp_dest = (i == 0 || i == 2 || i == 3) ? 2'd1 : 2'd2;
      exp_rdy  = (i == 2) ? 2'b00 : ((exp_dest == 2'd1) ? 2'b01 : 2'b10);
      @(negedge clk_i);
      checks++;
      if (up_b_valid_o !== 1'b1 || up_b_dest_o !== exp_dest || bk_b_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL b_rr_%0d: got valid=%b dest=%0d rdy=%b, expected 1, %0d, %b",
                 i, up_b_valid_o, up_b_dest_o, bk_b_ready_o, exp_dest, exp_rdy);
      end
      @(posedge clk_i); #2;
    end
    bk_b_valid_i = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(posedge clk_i); #2;
    load(0, 3'd0, 4'd3, 3'h1, 64'hE0);
    expect_d(4'h1, 3'd0, 64'hE0);
    drive_banks();
    wait_drain(20, n);
    for (int i = 0; i < 8; i++) begin
      load(0, 3'd5, 4'd6, 3'h3, 64'h300 + 64'(i));
      expect_d(4'h3, 3'd5, 64'h300 + 64'(i));
    end
    drive_banks();
    n = 0;
    while (bq0.size() > 5 && n < 20) begin
      @(posedge clk_i); #2;
      n++;
    end
    #1;
    up_a_valid_i = 1'b1; up_a_address_i = 64'h40; bk_a_ready_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (up_d_valid_o !== 1'b0 || bk_d_ready_o !== 2'b00 || up_a_ready_o !== 1'b0 || bk_a_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: got d_vld=%b d_rdy=%b a_rdy=%b a_vld=%b, expected all 0",
               up_d_valid_o, bk_d_ready_o, up_a_ready_o, bk_a_valid_o);
    end
    bq0.delete(); bq1.delete(); exp_q.delete();
    up_a_valid_i = 1'b0;
    drive_banks();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #2;
    load(0, 3'd0, 4'd3, 3'h0, 64'hF0); load(1, 3'd0, 4'd3, 3'h0, 64'hF1);
    expect_d(4'h0, 3'd0, 64'hF0); expect_d(4'h8, 3'd0, 64'hF1);
    drive_banks();
    wait_drain(20, n);
    checks++;
    if (n !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d cycles (%0d left), expected 2 cycles", n, exp_q.size());
    end
  endtask

  initial begin
    up_a_valid_i = 0; up_a_opcode_i = 0; up_a_param_i = 0; up_a_size_i = 4'd3; up_a_source_i = 0;
    up_a_address_i = 0; up_a_mask_i = 8'hFF; up_a_data_i = 0; up_a_corrupt_i = 0;
    up_c_valid_i = 0; up_c_opcode_i = 0; up_c_param_i = 0; up_c_size_i = 4'd3; up_c_source_i = 0;
    up_c_address_i = 0; up_c_data_i = 0; up_c_corrupt_i = 0;
    up_e_valid_i = 0; up_e_sink_i = 0; up_b_ready_i = 0; up_d_ready_i = 1;
    bk_a_ready_i = 0; bk_c_ready_i = 0; bk_e_ready_i = 0;
    bk_b_valid_i = 0; bk_b_opcode_i = 0; bk_b_param_i = 0; bk_b_size_i = 0;
    bk_b_address_i = 0; bk_b_dest_i = 0;
    bk_d_valid_i = 0; bk_d_opcode_i = 0; bk_d_param_i = 0; bk_d_size_i = 0; bk_d_source_i = 0;
    bk_d_sink_i = 0; bk_d_denied_i = 0; bk_d_data_i = 0; bk_d_corrupt_i = 0;
    test_reset();
    test_a_c_route();
    test_d_round_robin();
    test_d_burst_lock();
    test_d_burst_stall();
    test_sink_e();
    test_b_round_robin();
    test_reset_mid_burst();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
